// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex.
// The master modport is the producer/consumer side and the slave modport is the FIFO.
interface sync_fifo_flex_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             wr_en;
  logic [WIDTH-1:0] data_out;
  logic             rd_en;
  logic             err_clr;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, wr_en, rd_en, err_clr,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  data_in, wr_en, rd_en, err_clr,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with any depth, registered or fall-through read, fill count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flex #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 10,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_flex_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q, aempty_q, afull_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_ok, rd_ok;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Acceptance, pointer/count next state and sticky error next state.
  always_comb begin
    rd_ok    = bus.rd_en && !empty_q;
    wr_ok    = bus.wr_en && (!full_q || rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_ok) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Clear wins over a same-cycle rejection.
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d = ovf_q || (bus.wr_en && !wr_ok);
      udf_d = udf_q || (bus.rd_en && !rd_ok);
    end
  end

  // State registers; status flags are decoded from the next count so they track count_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == {CW{1'b0}});
      full_q   <= (count_d == CW'(DEPTH));
      aempty_q <= (count_d <= CW'(AEMPTY_THRESH));
      afull_q  <= (count_d >= CW'(AFULL_THRESH));
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem_q[rd_ptr_q];
    end else begin : g_regrd
      logic [WIDTH-1:0] data_out_q;

      // Registered read port: loads the head word only on an accepted pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out_q <= {WIDTH{1'b0}};
        end else if (rd_ok) begin
          data_out_q <= mem_q[rd_ptr_q];
        end
      end

      assign bus.data_out = data_out_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised synchronous FIFO, the next generation of the delay-line FIFO. Adds:
- non-power-of-two depth;
- a selectable read mode (registered read or first-word-fall-through);
- a fill count and programmable almost-full/almost-empty flags;
- sticky overflow/underflow error flags.

It sits between sample producers and consumers in the delay-line datapath and is used wherever an elastic buffer with occupancy visibility is needed.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 10, number of storage words (>=2, any integer, not restricted to powers of two).
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value (1..DEPTH).
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  WIDTH  write data
- wr_en  in  1  write request
- data_out  out  WIDTH  read data
- rd_en  in  1  read request / pop
- err_clr  in  1  synchronous clear of overflow/underflow
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AEMPTY_THRESH
- almost_full  out  1  count >= AFULL_THRESH
- count  out  CW  occupancy, CW = $clog2(DEPTH+1)
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (asynchronous assert, synchronous release): write/read pointers = 0, count = 0, data_out = 0, overflow = underflow = 0. Hence empty = 1, almost_empty = 1, full = 0, almost_full = 0 (for AFULL_THRESH >= 1). Memory contents are not reset. Reset mid-operation discards all stored data.
- Read acceptance: rd_ok = rd_en && !empty.
- Write acceptance: wr_ok = wr_en && (!full || rd_ok).
  - Simultaneous write and read when full: both accepted, count stays DEPTH.
  - Simultaneous write and read when empty: write accepted, read rejected.
- Pointers advance by 1 on each accepted operation and wrap from DEPTH-1 to 0. No power-of-two masking.
- count is registered:
  - +1 on wr_ok && !rd_ok;
  - -1 on rd_ok && !wr_ok;
  - unchanged otherwise.
- empty, full, almost_empty and almost_full are derived only from registered count. They change in the cycle after the causing edge and never depend combinationally on wr_en or rd_en.
- FWFT = 0 (registered read):
  - On a clk edge with rd_ok, data_out loads mem[rd_ptr]. It is visible after that edge, i.e. one-cycle read latency.
  - data_out holds its value when no read is accepted.
- FWFT = 1 (first-word-fall-through):
  - data_out = mem[rd_ptr] continuously. The head word is visible from the cycle after the write that makes count non-zero.
  - rd_en acknowledges and pops that word; the next word is visible after the edge.
  - data_out is valid only while !empty; its value while empty is unspecified and is not checked.
- Error flags:
  - overflow sets on any edge where wr_en && !wr_ok.
  - underflow sets on any edge where rd_en && !rd_ok.
  - Both hold until err_clr or reset. err_clr takes priority over a same-cycle set.
  - Rejected operations change no pointer, count or memory state.
- Data ordering: strict FIFO. Every accepted word is read exactly once, in write order, across any number of pointer wraps.

Test Plan:
- Reset and fill (DEPTH=10, FWFT=0): write 0x01..0x0A on consecutive cycles.
  - count steps 1..10.
  - almost_full asserts when count reaches 8.
  - full asserts after the 10th write.
  - An 11th write of 0xFF is rejected: overflow = 1, count stays 10.
- Drain (FWFT=0): rd_en for 10 cycles.
  - data_out reads 0x01..0x0A, each visible one cycle after its rd_en edge.
  - almost_empty asserts when count reaches 2; empty asserts after the last read.
  - An extra read gives underflow = 1 and data_out holds 0x0A.
- Simultaneous operations:
  - At full, write 0x55 and read together: count stays 10, 0x01 is output, 0x55 is later read last.
  - At empty, write 0x77 and read together: count becomes 1, underflow = 1, 0x77 is read next.
- FWFT=1: write 0xA5 into an empty FIFO.
  - Next cycle: empty = 0, data_out = 0xA5 without any rd_en.
  - Pulse rd_en with 0xA5 as the only word: empty = 1, count = 0.
- Wrap and ordering (DEPTH=10): run 1000 cycles of random wr_en/rd_en with an incrementing data pattern.
  - The scoreboard shows in-order data and count equal to writes minus reads.
  - overflow and underflow match the model.
  - Pointers are exercised across the 9->0 wrap.
- Reset mid-operation: with count = 6, pulse rst_n low asynchronously between edges.
  - Outputs return to reset values immediately.
  - After release, writing 0x3C and reading it returns 0x3C.
  - err_clr clears a previously set overflow in one cycle.
